// File: rtl/rom_arbiter_pkg.sv
// Shared instruction-bus widths, ROM map defaults and the response-slot state type.
package rom_arbiter_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 64;

    localparam logic [ADDR_W-1:0] ROM_BASE_ADDR_DEF = 64'h0000_0000_8000_0000;
    localparam int unsigned       ROM_DEPTH_DEF     = 64;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Misaligned, below base, or at/above base+span. One extra bit so the limit cannot wrap.
    function automatic logic rom_addr_err(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base,
                                          input logic [ADDR_W:0]   span);
        logic [ADDR_W:0] lim;
        lim = {1'b0, base} + span;
        return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= lim);
    endfunction

endpackage

// File: rtl/rom_arb_rsp_slot.sv
// Per-port response register: holds one ROM response until the consumer takes it.
module rom_arb_rsp_slot
    import rom_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    input  logic              i_grant,
    input  logic              i_err,
    input  logic [INST_W-1:0] i_data,
    input  logic              i_rsp_ready,
    output logic              o_eligible,
    output logic              o_rsp_valid,
    output logic [INST_W-1:0] o_rsp_data,
    output logic              o_rsp_err
);

    slot_state_e       r_state;
    slot_state_e       w_state_next;
    logic [INST_W-1:0] r_data;
    logic              r_err;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and eligibility; a full slot being drained this cycle may accept again
    always_comb begin
        w_state_next = r_state;
        o_eligible   = 1'b0;
        unique case (r_state)
            SLOT_EMPTY: begin
                o_eligible = i_req_valid;
                if (i_grant) begin
                    w_state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                o_eligible = i_req_valid && i_rsp_ready;
                if (i_rsp_ready && !i_grant) begin
                    w_state_next = SLOT_EMPTY;
                end
            end
            default: w_state_next = SLOT_EMPTY;
        endcase
    end

    // Response payload loads only on a grant, so it stays put during a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (i_grant) begin
            r_data <= i_data;
            r_err  <= i_err;
        end
    end

    assign o_rsp_valid = (r_state == SLOT_FULL);
    assign o_rsp_data  = r_data;
    assign o_rsp_err   = r_err;

endmodule

// File: rtl/rom_arbiter.sv
// Two-port (fetch / load) round-robin arbiter in front of a single combinational ROM.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = ROM_BASE_ADDR_DEF,
    parameter int unsigned       DEPTH     = ROM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [INST_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              if_rsp_ready,
    input  logic              ls_req_valid,
    input  logic [ADDR_W-1:0] ls_req_addr,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [INST_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,
    input  logic              ls_rsp_ready,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst
);

    localparam logic [ADDR_W:0] ROM_SPAN = (ADDR_W + 1)'(DEPTH) << 2;

    logic              w_if_elig;
    logic              w_ls_elig;
    logic              w_grant_if;
    logic              w_grant_ls;
    logic              w_rom_err;
    logic [INST_W-1:0] w_rsp_word;
    // 1: load port wins the next tie (fetch was granted last)
    logic              r_ls_prio;

    // Grant selection and ROM drive; nothing is granted while in reset
    always_comb begin
        w_grant_if = !rst && w_if_elig && (!w_ls_elig || !r_ls_prio);
        w_grant_ls = !rst && w_ls_elig && !w_grant_if;
        rom_ce     = w_grant_if || w_grant_ls;
        rom_addr   = '0;
        if (w_grant_if) begin
            rom_addr = if_req_addr;
        end else if (w_grant_ls) begin
            rom_addr = ls_req_addr;
        end
        w_rom_err  = rom_addr_err(rom_addr, BASE_ADDR, ROM_SPAN);
        w_rsp_word = w_rom_err ? '0 : rom_inst;
    end

    // Round-robin pointer moves only when someone is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ls_prio <= 1'b0;
        end else if (w_grant_if) begin
            r_ls_prio <= 1'b1;
        end else if (w_grant_ls) begin
            r_ls_prio <= 1'b0;
        end
    end

    assign if_req_ready = w_grant_if;
    assign ls_req_ready = w_grant_ls;

    rom_arb_rsp_slot u_if_slot (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (if_req_valid),
        .i_grant     (w_grant_if),
        .i_err       (w_rom_err),
        .i_data      (w_rsp_word),
        .i_rsp_ready (if_rsp_ready),
        .o_eligible  (w_if_elig),
        .o_rsp_valid (if_rsp_valid),
        .o_rsp_data  (if_rsp_data),
        .o_rsp_err   (if_rsp_err)
    );

    rom_arb_rsp_slot u_ls_slot (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (ls_req_valid),
        .i_grant     (w_grant_ls),
        .i_err       (w_rom_err),
        .i_data      (w_rsp_word),
        .i_rsp_ready (ls_rsp_ready),
        .o_eligible  (w_ls_elig),
        .o_rsp_valid (ls_rsp_valid),
        .o_rsp_data  (ls_rsp_data),
        .o_rsp_err   (ls_rsp_err)
    );

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_rom_arbiter;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] SPAN = 64'd256;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err, if_rsp_ready;
    logic        ls_req_valid, ls_req_ready, ls_rsp_valid, ls_rsp_err, ls_rsp_ready;
    logic [63:0] if_req_addr, ls_req_addr, rom_addr;
    logic [31:0] if_rsp_data, ls_rsp_data, rom_inst;
    logic        rom_ce;

    logic [31:0] mem [64];
    int          n_pass = 0;
    int          n_total = 0;

    rom_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .if_rsp_ready (if_rsp_ready),
        .ls_req_valid (ls_req_valid),
        .ls_req_addr  (ls_req_addr),
        .ls_req_ready (ls_req_ready),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_data  (ls_rsp_data),
        .ls_rsp_err   (ls_rsp_err),
        .ls_rsp_ready (ls_rsp_ready),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst)
    );

    always #5 clk = ~clk;

    // ROM model: out-of-window reads return garbage the arbiter must suppress
    logic [63:0] rom_off;
    always_comb begin
        rom_off  = rom_addr - BASE;
        rom_inst = 32'hDEAD_BEEF;
        if (rom_addr >= BASE && rom_addr < BASE + SPAN) rom_inst = mem[rom_off[7:2]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic bad_addr(input logic [63:0] a);
        return (a % 4 != 0) || (a < BASE) || (a - BASE >= SPAN);
    endfunction

    function automatic logic [31:0] word_at(input logic [63:0] a);
        logic [63:0] idx;
        idx = (a - BASE) / 4;
        return bad_addr(a) ? 32'h0 : mem[idx[5:0]];
    endfunction

    // Model: one pending response per port, plus who won the last grant
    logic        m_if_full, m_ls_full, m_if_err, m_ls_err, m_last_if;
    logic [31:0] m_if_data, m_ls_data;
    logic        n_if_full, n_ls_full, n_if_err, n_ls_err, n_last_if;
    logic [31:0] n_if_data, n_ls_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_if_full <= 1'b0; m_ls_full <= 1'b0; m_last_if <= 1'b0;
            m_if_err  <= 1'b0; m_ls_err  <= 1'b0; m_if_data <= '0; m_ls_data <= '0;
        end else begin
            m_if_full <= n_if_full; m_ls_full <= n_ls_full; m_last_if <= n_last_if;
            m_if_err  <= n_if_err;  m_ls_err  <= n_ls_err;
            m_if_data <= n_if_data; m_ls_data <= n_ls_data;
        end
    end

    // Compare process: every falling edge
    always @(negedge clk) begin
        logic e_if, e_ls, g_if, g_ls;
        n_if_full = m_if_full; n_ls_full = m_ls_full; n_last_if = m_last_if;
        n_if_err  = m_if_err;  n_ls_err  = m_ls_err;
        n_if_data = m_if_data; n_ls_data = m_ls_data;
        if (rst) begin
            check("rst_if_req_ready", if_req_ready, 0);
            check("rst_ls_req_ready", ls_req_ready, 0);
            check("rst_rom_ce", rom_ce, 0);
            check("rst_rom_addr", rom_addr, 0);
            check("rst_if_rsp", {if_rsp_valid, if_rsp_err, if_rsp_data}, 0);
            check("rst_ls_rsp", {ls_rsp_valid, ls_rsp_err, ls_rsp_data}, 0);
            n_if_full = 0; n_ls_full = 0; n_last_if = 0;
        end else begin
            e_if = if_req_valid && (!m_if_full || if_rsp_ready);
            e_ls = ls_req_valid && (!m_ls_full || ls_rsp_ready);
            g_if = e_if && (!e_ls || !m_last_if);
            g_ls = e_ls && !g_if;
            check("if_req_ready", if_req_ready, g_if);
            check("ls_req_ready", ls_req_ready, g_ls);
            check("rom_ce", rom_ce, g_if || g_ls);
            check("rom_addr", rom_addr, g_if ? if_req_addr : (g_ls ? ls_req_addr : 64'h0));
            check("if_rsp_valid", if_rsp_valid, m_if_full);
            check("ls_rsp_valid", ls_rsp_valid, m_ls_full);
            if (m_if_full) check("if_rsp_payload", {if_rsp_err, if_rsp_data}, {m_if_err, m_if_data});
            if (m_ls_full) check("ls_rsp_payload", {ls_rsp_err, ls_rsp_data}, {m_ls_err, m_ls_data});
            if (g_if) begin
                n_if_full = 1; n_if_data = word_at(if_req_addr); n_if_err = bad_addr(if_req_addr);
                n_last_if = 1;
            end else if (m_if_full && if_rsp_ready) n_if_full = 0;
            if (g_ls) begin
                n_ls_full = 1; n_ls_data = word_at(ls_req_addr); n_ls_err = bad_addr(ls_req_addr);
                n_last_if = 0;
            end else if (m_ls_full && ls_rsp_ready) n_ls_full = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1; if_req_valid = 0; ls_req_valid = 0;
        step();
        step();
        rst = 0;
    endtask

    logic [63:0] addr_tab [8];
    logic [1:0]  g;
    logic [31:0] held;

    initial begin
        mem[0] = 32'h0000_0413;
        for (int i = 1; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;
        addr_tab = '{64'h8000_0000, 64'h8000_0024, 64'h8000_00FC, 64'h8000_0100,
                     64'h8000_0031, 64'h7FFF_FFFC, 64'h8000_0080, 64'hFFFF_FFFF_FFFF_FFFC};
        rst = 1;
        if_req_valid = 1; if_req_addr = BASE; if_rsp_ready = 1;
        ls_req_valid = 1; ls_req_addr = BASE; ls_rsp_ready = 1;
        @(negedge clk);
        check("reset_gates_ready", {if_req_ready, ls_req_ready, rom_ce}, 0);

        // Single fetch of word 0
        step();
        rst = 0; ls_req_valid = 0; if_req_addr = 64'h8000_0000;
        @(negedge clk);
        check("fetch_ready", if_req_ready, 1);
        check("fetch_rom_addr", rom_addr, 64'h8000_0000);
        step();
        if_req_valid = 0;
        @(negedge clk);
        check("fetch_rsp", {if_rsp_valid, if_rsp_err, if_rsp_data}, {2'b10, 32'h0000_0413});

        // Alternation from reset
        do_reset();
        if_req_valid = 1; if_req_addr = 64'h8000_0004;
        ls_req_valid = 1; ls_req_addr = 64'h8000_0008;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            g = if_req_ready ? 2'd1 : (ls_req_ready ? 2'd2 : 2'd0);
            check("rr_grant", g, (k % 2 == 0) ? 2'd1 : 2'd2);
            step();
        end
        if_req_valid = 0; ls_req_valid = 0;

        // Load-port address errors and the last in-range word
        for (int k = 0; k < 4; k++) begin
            step();
            ls_req_valid = 1;
            ls_req_addr = (k == 0) ? 64'h8000_0100 : (k == 1) ? 64'h8000_0002 :
                          (k == 2) ? 64'h7FFF_FFFC : 64'h8000_00FC;
            step();
            ls_req_valid = 0;
            @(negedge clk);
            check("ls_err_rsp", {ls_rsp_valid, ls_rsp_err, ls_rsp_data},
                  (k == 3) ? {2'b10, 32'hC0DE_003F} : {2'b11, 32'h0});
        end

        // Fetch stall while load traffic keeps flowing
        step();
        if_req_valid = 1; if_req_addr = 64'h8000_0010; if_rsp_ready = 0;
        @(negedge clk);
        check("stall_first_grant", if_req_ready, 1);
        step();
        ls_req_valid = 1; ls_req_addr = 64'h8000_0020;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            held = if_rsp_data;
            check("stall_hold", {if_rsp_valid, if_rsp_err, held}, {2'b10, 32'hC0DE_0004});
            check("stall_ready", {if_req_ready, ls_req_ready}, 2'b01);
            step();
        end
        if_rsp_ready = 1; if_req_valid = 0; ls_req_valid = 0;
        @(negedge clk);
        check("stall_release_valid", if_rsp_valid, 1);
        step();
        @(negedge clk);
        check("stall_drained", {if_rsp_valid, ls_rsp_valid}, 2'b00);

        // Asynchronous reset with a pending fetch response
        step();
        if_req_valid = 1; if_req_addr = 64'h8000_0014; if_rsp_ready = 0;
        step();
        @(negedge clk);
        check("pre_rst_rsp", {if_rsp_valid, if_rsp_data}, {1'b1, 32'hC0DE_0005});
        #2 rst = 1;
        #1;
        check("async_rst_rsp", {if_rsp_valid, if_rsp_err, if_rsp_data}, 0);
        check("async_rst_req", {if_req_ready, rom_ce, rom_addr}, 0);
        step();
        rst = 0; if_req_valid = 0; if_rsp_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_quiet", if_rsp_valid, 0);
        end

        // Mixed directed traffic, checked by the model each cycle
        for (int i = 0; i < 48; i++) begin
            step();
            if_req_valid = (i % 3) != 0;
            ls_req_valid = (i % 2) == 1;
            if_rsp_ready = (i % 5) != 1;
            ls_rsp_ready = (i % 4) != 2;
            if_req_addr  = addr_tab[i % 8];
            ls_req_addr  = addr_tab[(i + 3) % 8];
        end
        step();
        if_req_valid = 0; ls_req_valid = 0; if_rsp_ready = 1; ls_rsp_ready = 1;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 64'h0000_0000_8000_0000, lowest byte address mapped to the ROM.
REQ-002 Parameter DEPTH, default 64, number of 32-bit ROM words; power of two.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 if_req_valid  input  1  fetch-port request valid.
REQ-006 if_req_addr  input  64  fetch-port byte address.
REQ-007 if_req_ready  output  1  fetch request accepted this cycle.
REQ-008 if_rsp_valid  output  1  fetch response valid.
REQ-009 if_rsp_data  output  32  fetch response word.
REQ-010 if_rsp_err  output  1  fetch address out of range or misaligned.
REQ-011 if_rsp_ready  input  1  fetch-port consumer accepts response.
REQ-012 ls_req_valid, ls_req_addr, ls_req_ready, ls_rsp_valid, ls_rsp_data, ls_rsp_err, ls_rsp_ready: load-port copies of REQ-005..REQ-011, same directions and widths.
REQ-013 rom_ce  output  1  chip enable to combinational ROM.
REQ-014 rom_addr  output  64  byte address to ROM.
REQ-015 rom_inst  input  32  ROM read data, valid same cycle as rom_ce/rom_addr.

Function
REQ-016 A port is eligible when req_valid=1 and its response register is empty or being consumed this cycle (rsp_valid=1 and rsp_ready=1).
REQ-017 At most one port is granted per cycle; grant asserts that port's req_ready combinationally in the same cycle.
REQ-018 Both eligible: round-robin; port not granted most recently wins; after reset the fetch port has priority.
REQ-019 One eligible: that port is granted regardless of round-robin state; round-robin pointer updates only on a grant.
REQ-020 On grant: rom_ce=1, rom_addr=granted req_addr; otherwise rom_ce=0, rom_addr=0.
REQ-021 Address check: err when addr[1:0]!=0, addr<BASE_ADDR, or addr>=BASE_ADDR+4*DEPTH (64-bit unsigned compare, no wrap).
REQ-022 On a granted request, at the next rising edge: rsp_valid=1, rsp_data=rom_inst (0 if err), rsp_err=err; latency exactly 1 cycle.
REQ-023 Response holds data/err stable while rsp_valid=1 and rsp_ready=0.
REQ-024 rsp_valid clears on the edge where rsp_valid=1 and rsp_ready=1, unless a new grant to that port occurs in the same cycle, in which case the new response loads (back-to-back, one per cycle).
REQ-025 Non-granted port with a pending response is unaffected by the other port's traffic.
REQ-026 Per-port state machine: EMPTY (rsp_valid=0) -> FULL on grant; FULL -> EMPTY on consume without grant; FULL -> FULL on consume with grant or on stall.
REQ-027 req_addr needs to be stable only in the grant cycle; no request buffering beyond the response register.

Reset
REQ-028 While rst=1: all req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, rom_ce=0, rom_addr=0, round-robin pointer set to favour fetch.
REQ-029 Reset asserted mid-transaction discards pending responses; no response emerges after reset deasserts without a new grant.

Structure
REQ-030 BASE_ADDR default, DEPTH default, and address-width constant reside in the shared defines file beside the existing instruction-bus widths.
REQ-031 One sub-module, rom_arb_rsp_slot, instantiated twice: per-port response register plus EMPTY/FULL state and eligibility output.

Verification
REQ-032 Fetch only, addr 0x8000_0000, rom word0=0x0000_0413, rsp_ready=1 -> if_req_ready same cycle, if_rsp_valid next cycle, data 0x0000_0413, err=0.
REQ-033 Both valid every cycle, both rsp_ready=1 -> grants alternate IF, LS, IF, LS starting with IF after reset.
REQ-034 ls_req_addr=0x8000_0100 (DEPTH=64) and 0x8000_0002 -> ls_rsp_err=1, data 0; 0x7FFF_FFFC -> err=1.
REQ-035 if_rsp_ready=0 for 5 cycles with if_req_valid=1 -> one response held stable, if_req_ready=0, ls port still granted each cycle.
REQ-036 Assert rst while if_rsp_valid=1 -> all outputs zero immediately (asynchronous), no response after release until new request.
